// File: rtl/traffic_pkg.sv
// Colour encoding and phase sequencing shared by the traffic-light bank,
// the display driver and the instruction decoder.
package traffic_pkg;

  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_GREEN  = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_OFF    = 2'd3;

  typedef logic [1:0] color_t;

  // RED -> GREEN -> YELLOW -> RED; the reserved code falls back to red.
  function automatic color_t next_color(input color_t c);
    case (c)
      COL_RED:   return COL_GREEN;
      COL_GREEN: return COL_YELLOW;
      default:   return COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Shared tick prescaler: one-cycle pulse every DIV enabled cycles; the
// count restarts from zero whenever en drops.
module tick_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  // Gating with en keeps a pending pulse from leaking into a stopped cycle.
  assign tick = tick_reg & en;

endmodule

// File: rtl/traffic_light_bank.sv
// Bank of independent red/green/yellow light sequencers sharing one tick
// prescaler, each with programmable durations and start colour.
module traffic_light_bank
  import traffic_pkg::*;
#(
  parameter int NUM_LIGHTS = 4,
  parameter int TIME_W     = 5,
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEF_RED    = 10,
  parameter int DEF_GREEN  = 10,
  parameter int DEF_YELLOW = 3,
  localparam int LW        = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [LW-1:0]           cfg_light,
  input  logic [1:0]              cfg_color,
  input  logic [TIME_W-1:0]       cfg_time,
  input  logic [1:0]              cfg_start,
  input  logic                    run,
  output logic                    cfg_err,
  output logic                    tick,
  output logic [2*NUM_LIGHTS-1:0] light_color
);

  logic run_q_reg;
  logic cfg_err_reg;
  logic cfg_bad;
  logic run_entry;

  assign cfg_bad   = (int'(cfg_light) >= NUM_LIGHTS) ||
                     (cfg_color == COL_OFF) || (cfg_start == COL_OFF);
  assign run_entry = run && !run_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      run_q_reg   <= run;
      cfg_err_reg <= cfg_valid && cfg_bad;
    end
  end

  assign cfg_err = cfg_err_reg;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick)
  );

  for (genvar gi = 0; gi < NUM_LIGHTS; gi++) begin : g_light
    logic [TIME_W-1:0] t_red_reg, t_green_reg, t_yellow_reg;
    logic [TIME_W-1:0] remain_reg, remain_next;
    logic [TIME_W-1:0] load_raw, load_val;
    logic [1:0]        start_col_reg, phase_reg, phase_next, col_reg;
    logic [1:0]        load_col;
    logic              wr_sel;

    assign wr_sel = cfg_valid && !cfg_bad && (cfg_light == LW'(gi));

    // Durations come from the registers, so a same-cycle write is not seen.
    assign load_col = run_entry ? start_col_reg : next_color(phase_reg);

    always_comb begin
      case (load_col)
        COL_RED:   load_raw = t_red_reg;
        COL_GREEN: load_raw = t_green_reg;
        default:   load_raw = t_yellow_reg;
      endcase
      load_val = (load_raw == '0) ? TIME_W'(1) : load_raw;
    end

    always_comb begin
      phase_next  = phase_reg;
      remain_next = remain_reg;
      if (!run) begin
        phase_next  = start_col_reg;
        remain_next = '0;
      end else if (run_entry) begin
        phase_next  = start_col_reg;
        remain_next = load_val;
      end else if (tick) begin
        if (remain_reg > TIME_W'(1)) begin
          remain_next = remain_reg - 1'b1;
        end else begin
          phase_next  = next_color(phase_reg);
          remain_next = load_val;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        t_red_reg     <= TIME_W'(DEF_RED);
        t_green_reg   <= TIME_W'(DEF_GREEN);
        t_yellow_reg  <= TIME_W'(DEF_YELLOW);
        start_col_reg <= COL_RED;
        phase_reg     <= COL_RED;
        remain_reg    <= '0;
        col_reg       <= COL_RED;
      end else begin
        if (wr_sel) begin
          case (cfg_color)
            COL_RED:    t_red_reg    <= cfg_time;
            COL_GREEN:  t_green_reg  <= cfg_time;
            COL_YELLOW: t_yellow_reg <= cfg_time;
            default:    ;
          endcase
          if (!run) start_col_reg <= cfg_start;
        end
        phase_reg  <= phase_next;
        remain_reg <= remain_next;
        col_reg    <= run ? phase_next : COL_RED;
      end
    end

    assign light_color[2*gi +: 2] = col_reg;
  end

endmodule

// File: tb/tb_traffic_light_bank.sv
// Directed bench for traffic_light_bank (4 lights, tick every 4 cycles):
// config-write table plus multi-cycle phase-timing sequences.
module tb_traffic_light_bank;

  localparam int NL  = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_light = '0;
  logic [1:0]   cfg_color = '0;
  logic [4:0]   cfg_time  = '0;
  logic [1:0]   cfg_start = '0;
  logic         run = 1'b0;
  logic         cfg_err;
  logic         tick;
  logic [7:0]   light_color;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_start [NL];
  int exp_dur   [NL][3];

  typedef struct {
    logic [1:0] light;
    logic [1:0] color;
    logic [4:0] tval;
    logic [1:0] start;
    logic       exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs [6];

  traffic_light_bank #(
    .NUM_LIGHTS (NL),
    .TIME_W     (5),
    .TICK_DIV   (DIV),
    .DEF_RED    (10),
    .DEF_GREEN  (10),
    .DEF_YELLOW (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_light   (cfg_light),
    .cfg_color   (cfg_color),
    .cfg_time    (cfg_time),
    .cfg_start   (cfg_start),
    .run         (run),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .light_color (light_color)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    for (int i = 0; i < NL; i++) begin
      exp_start[i]  = 0;
      exp_dur[i][0] = 10;
      exp_dur[i][1] = 10;
      exp_dur[i][2] = 3;
    end
  endtask

  // Colour of light li k cycles after the run-entry edge, walking the phases.
  function automatic logic [1:0] model_color(input int li, input int k);
    int p = exp_start[li];
    int t = 0;
    int d;
    for (int g = 0; g < 64; g++) begin
      d = ((exp_dur[li][p] == 0) ? 1 : exp_dur[li][p]) * DIV;
      if (k < t + d) return 2'(p);
      t += d;
      p = (p == 2) ? 0 : p + 1;
    end
    return 2'd3;
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    logic [7:0] v = '0;
    for (int li = 0; li < NL; li++) v[2*li +: 2] = model_color(li, k);
    return v;
  endfunction

  // Caller sets run=1 (and optionally a config write); this edge is run entry.
  task automatic run_check(input string tag, input int n);
    cycle();
    cfg_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s colors k=%0d", tag, k), 32'(light_color), 32'(exp_vec(k)));
      check($sformatf("%s tick k=%0d", tag, k), 32'(tick), 32'((k % DIV) == DIV - 1));
      check($sformatf("%s cfg_err k=%0d", tag, k), 32'(cfg_err), 32'd0);
      cycle();
    end
  endtask

  task automatic stop_check(input string tag, input int n);
    run = 1'b0;
    for (int k = 0; k < n; k++) begin
      cycle();
      check($sformatf("%s stopped colors c=%0d", tag, k), 32'(light_color), 32'd0);
      check($sformatf("%s stopped tick c=%0d", tag, k), 32'(tick), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] ev;

    vecs[0] = '{light: 2'd2, color: 2'd1, tval: 5'd2,  start: 2'd1, exp_err: 1'b0};
    vecs[1] = '{light: 2'd0, color: 2'd3, tval: 5'd7,  start: 2'd0, exp_err: 1'b1};
    vecs[2] = '{light: 2'd1, color: 2'd0, tval: 5'd9,  start: 2'd3, exp_err: 1'b1};
    vecs[3] = '{light: 2'd3, color: 2'd2, tval: 5'd0,  start: 2'd0, exp_err: 1'b0};
    vecs[4] = '{light: 2'd2, color: 2'd2, tval: 5'd1,  start: 2'd3, exp_err: 1'b1};
    vecs[5] = '{light: 2'd0, color: 2'd3, tval: 5'd1,  start: 2'd3, exp_err: 1'b1};

    // Reset state
    cycle();
    cycle();
    check("reset colors", 32'(light_color), 32'd0);
    check("reset cfg_err", 32'(cfg_err), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    rst = 1'b0;
    cycle();
    check("idle colors", 32'(light_color), 32'd0);

    // Defaults, with light 1 red shortened to 1 while its red has 5 ticks left
    set_defaults();
    run = 1'b1;
    cycle();
    for (int k = 0; k < 100; k++) begin
      ev = exp_vec(k);
      if (k >= 92) ev[3:2] = (k < 96) ? 2'd0 : 2'd1;
      check($sformatf("midred colors k=%0d", k), 32'(light_color), 32'(ev));
      check($sformatf("midred tick k=%0d", k), 32'(tick), 32'((k % DIV) == DIV - 1));
      check($sformatf("midred cfg_err k=%0d", k), 32'(cfg_err), 32'd0);
      if (k == 20) begin
        cfg_valid = 1'b1; cfg_light = 2'd1; cfg_color = 2'd0; cfg_time = 5'd1; cfg_start = 2'd0;
      end else begin
        cfg_valid = 1'b0;
      end
      cycle();
    end
    stop_check("midred", 1);

    // Config-write table while stopped
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_light = vecs[i].light;
      cfg_color = vecs[i].color;
      cfg_time  = vecs[i].tval;
      cfg_start = vecs[i].start;
      cycle();
      cfg_valid = 1'b0;
      check($sformatf("cfg[%0d] err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      cycle();
      check($sformatf("cfg[%0d] err width", i), 32'(cfg_err), 32'd0);
    end
    set_defaults();
    exp_start[2]  = 1;
    exp_dur[2][1] = 2;
    exp_dur[3][2] = 0;

    // Run, drop mid-green, restart from start colours with full durations
    run = 1'b1;
    run_check("runA", 60);
    stop_check("dropA", 3);
    run = 1'b1;
    run_check("runB", 100);

    // Reset while running: red next cycle, durations back to defaults
    rst = 1'b1;
    cycle();
    check("midrun reset colors", 32'(light_color), 32'd0);
    check("midrun reset cfg_err", 32'(cfg_err), 32'd0);
    check("midrun reset tick", 32'(tick), 32'd0);
    rst = 1'b0;
    set_defaults();
    run_check("runC", 100);
    stop_check("dropC", 1);

    // Write coincident with run entry: duration committed, start colour not
    run = 1'b1;
    cfg_valid = 1'b1; cfg_light = 2'd0; cfg_color = 2'd1; cfg_time = 5'd1; cfg_start = 2'd1;
    exp_dur[0][1] = 1;
    run_check("entry_wr", 60);
    stop_check("dropD", 1);
    run = 1'b1;
    run_check("entry_wr2", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
